// File: rtl/mux_arb_pkg.sv
// Shared types for the four-lane round-robin arbiter.
// Holds the FSM state enum, lane count and grant index type.
package mux_arb_pkg;

    localparam int NUM_REQ = 4;

    typedef logic [1:0] grant_t;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        SEND
    } arb_state_t;

endpackage

// File: rtl/rr_grant.sv
// Rotating priority encoder: picks the first valid lane after last_grant.
// Ports: req_valid[3:0], last_grant[1:0] in; any, winner[1:0] out.
module rr_grant
    import mux_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_valid,
    input  grant_t             last_grant,
    output logic               any,
    output grant_t             winner
);

    grant_t idx;

    // Walk from lowest to highest priority so the closest lane after
    // last_grant overwrites everything else. Offset 4 is last_grant itself.
    always_comb begin
        winner = last_grant;
        idx    = last_grant;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = last_grant + grant_t'(k);
            if (req_valid[idx]) begin
                winner = idx;
            end
        end
        any = |req_valid;
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing one registered valid/ready channel among 4 lanes.
// Ports: clk, rst_n, req_valid[3:0], req_data0..3, req_ready[3:0],
//        out_valid, out_data, out_ready, sel[1:0], busy.
// Optional: define ARB_LOCK_EN to add req_lock[3:0] (hold grant on a lane).
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       req_valid,
    input  logic [WIDTH:0]   req_data0,
    input  logic [WIDTH:0]   req_data1,
    input  logic [WIDTH:0]   req_data2,
    input  logic [WIDTH:0]   req_data3,
`ifdef ARB_LOCK_EN
    input  logic [3:0]       req_lock,
`endif
    output logic [3:0]       req_ready,
    output logic             out_valid,
    output logic [WIDTH:0]   out_data,
    input  logic             out_ready,
    output logic [1:0]       sel,
    output logic             busy
);

    arb_state_t     state, state_nx;
    grant_t         sel_nx;
    grant_t         last_grant, last_nx;
    grant_t         ptr;
    grant_t         winner;
    logic           any;
    logic           keep;
    logic           ov_nx;
    logic [WIDTH:0] od_nx;
    logic [WIDTH:0] sel_data;

    // In SEND the search must already see the pointer that the
    // handshake is about to write, i.e. the current sel.
    assign ptr = (state == SEND) ? sel : last_grant;

    rr_grant u_rr_grant (
        .req_valid  (req_valid),
        .last_grant (ptr),
        .any        (any),
        .winner     (winner)
    );

`ifdef ARB_LOCK_EN
    assign keep = req_lock[sel] & req_valid[sel];
`else
    assign keep = 1'b0;
`endif

    always_comb begin
        case (sel)
            2'd0:    sel_data = req_data0;
            2'd1:    sel_data = req_data1;
            2'd2:    sel_data = req_data2;
            default: sel_data = req_data3;
        endcase
    end

    always_comb begin
        req_ready = '0;
        if (state == GRANT) begin
            req_ready[sel] = 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        sel_nx   = sel;
        last_nx  = last_grant;
        ov_nx    = out_valid;
        od_nx    = out_data;
        case (state)
            IDLE: begin
                if (any) begin
                    sel_nx   = winner;
                    state_nx = GRANT;
                end
            end
            GRANT: begin
                if (req_valid[sel]) begin
                    od_nx    = sel_data;
                    ov_nx    = 1'b1;
                    state_nx = SEND;
                end else begin
                    state_nx = IDLE;
                end
            end
            SEND: begin
                if (out_ready) begin
                    ov_nx = 1'b0;
                    if (keep) begin
                        state_nx = GRANT;
                    end else begin
                        last_nx = sel;
                        if (any) begin
                            sel_nx   = winner;
                            state_nx = GRANT;
                        end else begin
                            state_nx = IDLE;
                        end
                    end
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sel        <= 2'd0;
            last_grant <= 2'd3;
            out_valid  <= 1'b0;
            out_data   <= '0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nx;
            sel        <= sel_nx;
            last_grant <= last_nx;
            out_valid  <= ov_nx;
            out_data   <= od_nx;
            busy       <= (state_nx != IDLE);
        end
    end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter with a word scoreboard.
// Lock scenario runs only when ARB_LOCK_EN is defined.
module tb_mux_rr_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req_valid;
    logic [8:0] req_data0, req_data1, req_data2, req_data3;
    logic [3:0] req_lock;
    logic [3:0] req_ready;
    logic       out_valid;
    logic [8:0] out_data;
    logic       out_ready;
    logic [1:0] sel;
    logic       busy;

    int vectors = 0;
    int miscompares = 0;
    logic [8:0] expq[$];

    mux_rr_arbiter #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data0 (req_data0),
        .req_data1 (req_data1),
        .req_data2 (req_data2),
        .req_data3 (req_data3),
`ifdef ARB_LOCK_EN
        .req_lock  (req_lock),
`endif
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .sel       (sel),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = 4'b0000;
        req_lock  = 4'b0000;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    // Waits (bounded) for the next out_valid, checks word and gap.
    task automatic wait_word(input string tag, input int gap);
        int n;
        logic [8:0] e;
        n = 0;
        do begin
            step();
            n++;
        end while (!out_valid && n < 8);
        chk({tag, "_valid"}, out_valid, 1);
        e = (expq.size() > 0) ? expq.pop_front() : 9'h000;
        chk({tag, "_data"}, out_data, e);
        chk({tag, "_gap"}, n, gap);
    endtask

    initial begin
        req_data0 = 9'h000;
        req_data1 = 9'h000;
        req_data2 = 9'h000;
        req_data3 = 9'h000;
        do_reset();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_sel", sel, 0);
        chk("rst_busy", busy, 0);
        chk("rst_req_ready", req_ready, 0);

        // single request on lane 2
        req_data2 = 9'h0A5;
        req_valid = 4'b0100;
        expq.push_back(9'h0A5);
        step();
        chk("single_sel", sel, 2);
        chk("single_ready", req_ready, 4'b0100);
        chk("single_busy", busy, 1);
        chk("single_ov0", out_valid, 0);
        step();
        req_valid = 4'b0000;
        chk("single_ov", out_valid, 1);
        chk("single_data", out_data, expq.pop_front());
        chk("single_ready_send", req_ready, 0);
        step();
        chk("single_ov_end", out_valid, 0);
        chk("single_idle", busy, 0);
        chk("single_sel_hold", sel, 2);

        // all four lanes requesting
        do_reset();
        req_data0 = 9'h011;
        req_data1 = 9'h022;
        req_data2 = 9'h033;
        req_data3 = 9'h044;
        expq.push_back(9'h011);
        expq.push_back(9'h022);
        expq.push_back(9'h033);
        expq.push_back(9'h044);
        expq.push_back(9'h011);
        req_valid = 4'b1111;
        for (int w = 0; w < 5; w++) begin
            wait_word("rr", 2);
        end
        req_valid = 4'b0000;
        step();

        // backpressure, full-width word on lane 0
        do_reset();
        req_data0 = 9'h1FF;
        out_ready = 1'b0;
        req_valid = 4'b0001;
        expq.push_back(9'h1FF);
        wait_word("bp", 2);
        req_valid = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_ov_hold", out_valid, 1);
            chk("bp_data_hold", out_data, 9'h1FF);
            chk("bp_ready_low", req_ready, 0);
        end
        out_ready = 1'b1;
        step();
        chk("bp_done_ov", out_valid, 0);
        chk("bp_done_busy", busy, 0);

        // withdraw: lane 0 served, lane 1 drops in GRANT
        do_reset();
        req_data0 = 9'h0F0;
        req_valid = 4'b0001;
        expq.push_back(9'h0F0);
        wait_word("wd_pre", 2);
        req_valid = 4'b0000;
        step();
        req_valid = 4'b0010;
        step();
        chk("wd_sel", sel, 1);
        chk("wd_ready", req_ready, 4'b0010);
        req_valid = 4'b0000;
        step();
        chk("wd_ov", out_valid, 0);
        chk("wd_idle", busy, 0);
        req_valid = 4'b0011;
        step();
        chk("wd_regrant", sel, 1);
        req_valid = 4'b0000;
        step();
        step();

        // asynchronous reset in SEND
        do_reset();
        req_data0 = 9'h155;
        out_ready = 1'b0;
        req_valid = 4'b0010;
        step();
        step();
        chk("ar_send_ov", out_valid, 1);
        chk("ar_send_sel", sel, 1);
        req_valid = 4'b0000;
        #2 rst_n = 1'b0;
        #1;
        chk("ar_ov", out_valid, 0);
        chk("ar_sel", sel, 0);
        chk("ar_busy", busy, 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        req_valid = 4'b1001;
        out_ready = 1'b1;
        step();
        chk("ar_grant", sel, 0);
        chk("ar_ready", req_ready, 4'b0001);
        step();
        chk("ar_data", out_data, 9'h155);
        req_valid = 4'b0000;
        step();

`ifdef ARB_LOCK_EN
        // lock keeps lane 1 for three words, then lane 3
        do_reset();
        req_data1 = 9'h101;
        req_data3 = 9'h0C3;
        req_valid = 4'b1010;
        req_lock  = 4'b0010;
        expq.push_back(9'h101);
        expq.push_back(9'h101);
        expq.push_back(9'h101);
        expq.push_back(9'h0C3);
        wait_word("lk1", 2);
        chk("lk1_sel", sel, 1);
        wait_word("lk2", 2);
        chk("lk2_sel", sel, 1);
        wait_word("lk3", 2);
        chk("lk3_sel", sel, 1);
        req_lock = 4'b0000;
        wait_word("lk4", 2);
        chk("lk4_sel", sel, 3);
        req_valid = 4'b0000;
        step();
`endif

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
